// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 52;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first serialiser with
// optional parity and one or two stop bits on an idle-high line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [7:0]                          tx_data,
  input  logic                                tx_valid,
  output logic                                tx_ready,
  output logic                                serial_out,
  output logic                                busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

  localparam int unsigned     CntW       = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] BaudReload = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LastStop   = 3'(STOP_BITS - 1);
  localparam logic            ParInit    = (PARITY == PAR_ODD);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("CLKS_PER_BIT must be >= 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end

  tx_state_e       state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            line_q;

  logic            fifo_full, fifo_empty, pop, bit_end, frame_done;
  logic [7:0]      fifo_data;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tx_valid),
    .push_data(tx_data),
    .pop      (pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bit_end    = (baud_q == '0);
  assign frame_done = (state_q == StStop) && bit_end && (bit_q == LastStop);
  // Popping at the end of the last stop bit chains frames with no idle gap.
  assign pop        = !fifo_empty && ((state_q == StIdle) || frame_done);

  assign tx_ready   = !fifo_full;
  assign serial_out = line_q;
  assign busy       = (state_q != StIdle) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      // The line register follows the state one cycle later.
      unique case (state_q)
        StIdle:   line_q <= 1'b1;
        StStart:  line_q <= 1'b0;
        StData:   line_q <= shift_q[0];
        StParity: line_q <= par_q;
        default:  line_q <= 1'b1;
      endcase

      if (pop) begin
        shift_q <= fifo_data;
        par_q   <= ParInit;
        baud_q  <= BaudReload;
        bit_q   <= '0;
        state_q <= StStart;
      end else if (state_q != StIdle) begin
        if (!bit_end) begin
          baud_q <= baud_q - 1'b1;
        end else begin
          baud_q <= BaudReload;
          unique case (state_q)
            StStart: begin
              bit_q   <= '0;
              state_q <= StData;
            end
            StData: begin
              shift_q <= shift_q >> 1;
              par_q   <= par_q ^ shift_q[0];
              bit_q   <= bit_q + 1'b1;
              if (bit_q == 3'd7) begin
                state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
              end
            end
            StParity: begin
              bit_q   <= '0;
              state_q <= StStop;
            end
            StStop: begin
              if (bit_q == LastStop) begin
                bit_q   <= '0;
                state_q <= StIdle;
              end else begin
                bit_q <= bit_q + 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: directed vectors, frame-timing
// sequences and randomized traffic checked against a frame-level line model.
module tb_uart_tx_buffered;

  localparam int NI = 5;

  // Instance configurations: default, even parity, odd parity, two stops, fast random.
  int cpb_a  [NI] = '{52, 52, 52, 52, 3};
  int par_a  [NI] = '{0, 2, 1, 0, 2};
  int stop_a [NI] = '{1, 1, 1, 2, 2};
  int dep_a  [NI] = '{4, 4, 4, 4, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid_v [NI];
  logic       tx_ready_v [NI];
  logic       serial_v   [NI];
  logic       busy_v     [NI];
  logic [2:0] cnt_v      [4];
  logic [1:0] cnt_r;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(52), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
    .tx_ready(tx_ready_v[0]), .serial_out(serial_v[0]), .busy(busy_v[0]),
    .fifo_count(cnt_v[0]));
  uart_tx_buffered #(.CLKS_PER_BIT(52), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_v[1]),
    .tx_ready(tx_ready_v[1]), .serial_out(serial_v[1]), .busy(busy_v[1]),
    .fifo_count(cnt_v[1]));
  uart_tx_buffered #(.CLKS_PER_BIT(52), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_v[2]),
    .tx_ready(tx_ready_v[2]), .serial_out(serial_v[2]), .busy(busy_v[2]),
    .fifo_count(cnt_v[2]));
  uart_tx_buffered #(.CLKS_PER_BIT(52), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_v[3]),
    .tx_ready(tx_ready_v[3]), .serial_out(serial_v[3]), .busy(busy_v[3]),
    .fifo_count(cnt_v[3]));
  uart_tx_buffered #(.CLKS_PER_BIT(3), .FIFO_DEPTH(2), .PARITY(2), .STOP_BITS(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid_v[4]),
    .tx_ready(tx_ready_v[4]), .serial_out(serial_v[4]), .busy(busy_v[4]),
    .fifo_count(cnt_r));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic checkn(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int         cur;
  int         m_t;
  int         m_p;
  bit         m_active;
  logic [7:0] m_byte;
  logic [7:0] m_q [$];
  logic       obs_line, obs_busy;
  bit         acc;

  function automatic logic frame_bit(input logic [7:0] b, input int par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par != 0) return (^b) ^ (par == 1);
    return 1'b1;
  endfunction

  function automatic int frame_len(input int i);
    return (9 + ((par_a[i] != 0) ? 1 : 0) + stop_a[i]) * cpb_a[i];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_t = 0;
    m_p = 0;
  endtask

  task automatic get_obs(input int i, output logic line, output logic bsy, output logic rdy,
                         output logic [2:0] cnt);
    line = serial_v[i];
    bsy  = busy_v[i];
    rdy  = tx_ready_v[i];
    cnt  = (i == 4) ? {1'b0, cnt_r} : cnt_v[i[1:0]];
  endtask

  // One clock: advance the model across the edge, then compare all outputs.
  task automatic step(output bit accepted);
    int         len, o;
    bit         do_pop, do_push;
    logic [7:0] din;
    logic       line, bsy, rdy, exp_line;
    logic [2:0] cnt;
    len     = frame_len(cur);
    do_pop  = (m_q.size() != 0) && (!m_active || (m_t + 1 >= m_p + len));
    do_push = (tx_valid_v[cur] == 1'b1) && (m_q.size() < dep_a[cur]);
    din     = tx_data;
    @(posedge clk);
    m_t++;
    if (do_pop) begin
      m_byte   = m_q.pop_front();
      m_p      = m_t;
      m_active = 1'b1;
    end
    if (do_push) m_q.push_back(din);
    #1;
    o = m_t - 1 - m_p;
    exp_line = (m_active && o >= 0 && o < len) ? frame_bit(m_byte, par_a[cur], o / cpb_a[cur])
                                               : 1'b1;
    get_obs(cur, line, bsy, rdy, cnt);
    check1("serial_out", line, exp_line);
    check1("busy", bsy, (m_active && (m_t < m_p + len)) || (m_q.size() != 0));
    check1("tx_ready", rdy, m_q.size() < dep_a[cur]);
    checkn("fifo_count", 32'(cnt), m_q.size());
    obs_line = line;
    obs_busy = bsy;
    accepted = do_push;
  endtask

  task automatic send_byte(input logic [7:0] b, output int at);
    bit a;
    a = 1'b0;
    tx_data = b;
    tx_valid_v[cur] = 1'b1;
    for (int n = 0; n < 4000 && !a; n++) step(a);
    tx_valid_v[cur] = 1'b0;
    at = m_t;
    check1("accept_timeout", a, 1'b1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int         inst;
    logic [7:0] data;
    int         k;       // edges after the accepting edge
    logic       line;
    logic       busy;
  } vec_t;

  vec_t vecs [$];
  logic line_log [1300];
  logic busy_log [1300];

  task automatic add_vec(input int inst, input logic [7:0] data, input int k,
                         input logic line, input logic busy);
    vec_t v;
    v.inst = inst; v.data = data; v.k = k; v.line = line; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic run_txn(input int inst, input logic [7:0] data, input int nsteps);
    int e0;
    cur = inst;
    send_byte(data, e0);
    line_log[0] = obs_line;
    busy_log[0] = obs_busy;
    for (int k = 1; k < nsteps; k++) begin
      step(acc);
      line_log[m_t - e0] = obs_line;
      busy_log[m_t - e0] = obs_busy;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e, t_idle, run, first_low;
    int last_inst;
    logic [7:0] last_data;

    for (int i = 0; i < NI; i++) tx_valid_v[i] = 1'b0;
    cur = 0;
    acc = 1'b0;
    model_reset();

    // Reset held: every instance shows idle values.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check1("rst_serial_out", serial_v[i], 1'b1);
      check1("rst_tx_ready", tx_ready_v[i], 1'b1);
      check1("rst_busy", busy_v[i], 1'b0);
    end
    checkn("rst_fifo_count", 32'(cnt_v[0]), 0);
    rst_n = 1'b1;

    // Idle for 1000 cycles with no stimulus.
    repeat (1000) step(acc);

    // Single-frame vectors: 0x48 default, 0x07 even parity, 0x07 odd parity.
    add_vec(0, 8'h48, 0, 1, 1);    add_vec(0, 8'h48, 1, 1, 1);
    add_vec(0, 8'h48, 2, 0, 1);    add_vec(0, 8'h48, 53, 0, 1);
    add_vec(0, 8'h48, 54, 0, 1);   add_vec(0, 8'h48, 209, 0, 1);
    add_vec(0, 8'h48, 210, 1, 1);  add_vec(0, 8'h48, 261, 1, 1);
    add_vec(0, 8'h48, 262, 0, 1);  add_vec(0, 8'h48, 366, 1, 1);
    add_vec(0, 8'h48, 418, 0, 1);  add_vec(0, 8'h48, 469, 0, 1);
    add_vec(0, 8'h48, 470, 1, 1);  add_vec(0, 8'h48, 520, 1, 1);
    add_vec(0, 8'h48, 521, 1, 0);
    add_vec(1, 8'h07, 2, 0, 1);    add_vec(1, 8'h07, 469, 0, 1);
    add_vec(1, 8'h07, 470, 1, 1);  add_vec(1, 8'h07, 521, 1, 1);
    add_vec(1, 8'h07, 572, 1, 1);  add_vec(1, 8'h07, 573, 1, 0);
    add_vec(2, 8'h07, 469, 0, 1);  add_vec(2, 8'h07, 470, 0, 1);
    add_vec(2, 8'h07, 521, 0, 1);  add_vec(2, 8'h07, 522, 1, 1);
    add_vec(2, 8'h07, 572, 1, 1);  add_vec(2, 8'h07, 573, 1, 0);

    last_inst = -1;
    last_data = 8'h00;
    for (int v = 0; v < vecs.size(); v++) begin
      if (vecs[v].inst != last_inst || vecs[v].data != last_data) begin
        model_reset();
        run_txn(vecs[v].inst, vecs[v].data, 600);
        last_inst = vecs[v].inst;
        last_data = vecs[v].data;
      end
      check1($sformatf("vec%0d_line_k%0d", v, vecs[v].k), line_log[vecs[v].k], vecs[v].line);
      check1($sformatf("vec%0d_busy_k%0d", v, vecs[v].k), busy_log[vecs[v].k], vecs[v].busy);
    end

    // Six bytes on consecutive cycles into a 4-deep FIFO.
    cur = 0;
    model_reset();
    send_byte(8'h00, e0);
    for (int b = 1; b <= 4; b++) send_byte(8'(b), e);
    checkn("burst_5th_accept_edge", e - e0, 4);
    check1("burst_full_ready", tx_ready_v[0], 1'b0);
    checkn("burst_full_count", 32'(cnt_v[0]), 4);
    send_byte(8'h05, e);
    checkn("burst_6th_accept_edge", e - e0, 522);
    t_idle = -1;
    for (int n = 0; n < 4000 && t_idle < 0; n++) begin
      step(acc);
      if (!obs_busy) t_idle = m_t - e0;
    end
    checkn("burst_total_cycles", t_idle, 3121);

    // Reset mid-frame during data bit 3 of 0xA5 with two bytes queued.
    model_reset();
    send_byte(8'hA5, e0);
    send_byte(8'h11, e);
    send_byte(8'h22, e);
    while (m_t - e0 < 230) step(acc);
    check1("pre_rst_line_bit3", serial_v[0], 1'b0);
    checkn("pre_rst_count", 32'(cnt_v[0]), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_serial_out", serial_v[0], 1'b1);
    checkn("mid_rst_fifo_count", 32'(cnt_v[0]), 0);
    check1("mid_rst_busy", busy_v[0], 1'b0);
    check1("mid_rst_tx_ready", tx_ready_v[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run_txn(0, 8'h3C, 600);
    check1("post_rst_bit2", line_log[2 + 3 * 52 + 20], 1'b1);

    // Two stop bits, back-to-back 0x55 then 0xAA.
    model_reset();
    cur = 3;
    send_byte(8'h55, e0);
    line_log[0] = obs_line;
    busy_log[0] = obs_busy;
    send_byte(8'hAA, e);
    checkn("stop2_second_accept", e - e0, 1);
    line_log[1] = obs_line;
    busy_log[1] = obs_busy;
    while (m_t - e0 < 1299) begin
      step(acc);
      line_log[m_t - e0] = obs_line;
      busy_log[m_t - e0] = obs_busy;
    end
    check1("stop2_bit7_low", line_log[469], 1'b0);
    run = 0;
    while (run < 400 && line_log[470 + run] == 1'b1) run++;
    checkn("stop2_high_run", run, 104);
    check1("stop2_next_start", line_log[574], 1'b0);
    first_low = -1;
    for (int k = 1; k < 1300; k++) if (first_low < 0 && busy_log[k] == 1'b0) first_low = k;
    checkn("stop2_busy_low_edge", first_low, 1145);

    // Randomized traffic on the fast instance.
    model_reset();
    cur = 4;
    acc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (tx_valid_v[4] == 1'b0 || acc) begin
        tx_valid_v[4] = ($urandom_range(0, 99) < ((n < 1500) ? 70 : 15));
        tx_data = 8'($urandom);
      end
      step(acc);
    end
    tx_valid_v[4] = 1'b0;
    repeat (300) step(acc);
    check1("rand_drain_busy", busy_v[4], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
